bsg_mesh_router_wormhole_buffered: RTL and testbench

Input-buffered, wormhole-switched mesh router for multi-flit packets. Each input port has a parametrised FIFO. Header flits are routed by dimension-ordered (XY or YX) routing. An output port is locked to the winning input until that packet's tail flit has passed. It sits at every tile of a 1D or 2D mesh in place of the single-flit router, so that cache-line and DMA packets traverse the network without being interleaved.

---
 rtl/bsg_mesh_router_pkg.sv | 27 ++
 rtl/bsg_mesh_router_wormhole_input.sv | 128 ++++++++++++
 rtl/bsg_mesh_router_wormhole_buffered.sv | 126 ++++++++++++
 tb/tb_bsg_mesh_router_wormhole_buffered.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mesh_router_pkg.sv
// rtl/bsg_mesh_router_pkg.sv - shared types and direction indices for the wormhole mesh router
`ifndef BSG_MESH_ROUTER_PKG_SV
`define BSG_MESH_ROUTER_PKG_SV

// Header flit layout, LSB first: x, then y, then body-flit count.
`define BSG_MESH_ROUTER_WH_HEADER_S(x_w, y_w, l_w) \
    struct packed { \
        logic [l_w-1:0] len; \
        logic [y_w-1:0] y; \
        logic [x_w-1:0] x; \
    }

package bsg_mesh_router_pkg;

    // Port indices in bsg_noc_pkg direction order.
    localparam int dir_p = 0;
    localparam int dir_w = 1;
    localparam int dir_e = 2;
    localparam int dir_n = 3;
    localparam int dir_s = 4;

    typedef enum logic {eHeader, eBody} wh_in_state_e;
    typedef enum logic {eIdle, eLocked} wh_out_state_e;

endpackage

`endif

// File: rtl/bsg_mesh_router_wormhole_input.sv
// rtl/bsg_mesh_router_wormhole_input.sv - per-port input FIFO, DOR decoder and packet-tracking FSM
module bsg_mesh_router_wormhole_input
    import bsg_mesh_router_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int x_cord_width_p = 3,
    parameter int y_cord_width_p = 3,
    parameter int len_width_p    = 4,
    parameter int dims_p         = 2,
    parameter int dirs_lp        = 2*dims_p+1,
    parameter int fifo_els_p     = 2,
    parameter int XY_order_p     = 1,
    parameter int debug_p        = 0,
    parameter int port_id_p      = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic [dirs_lp-1:0]        req_o,
    output logic                      is_header_o,
    output logic                      is_tail_o,
    input  logic                      yumi_i
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = $clog2(fifo_els_p+1);
    localparam int hdr_w_lp = x_cord_width_p + y_cord_width_p + len_width_p;

    typedef `BSG_MESH_ROUTER_WH_HEADER_S(x_cord_width_p, y_cord_width_p, len_width_p) header_s;

    logic [width_p-1:0]  mem_r [fifo_els_p];
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                full, enq;

    header_s             hdr;
    int                  x_dir, y_dir, route_idx;
    logic [dirs_lp-1:0]  route_oh;

    wh_in_state_e        state_r;
    logic [len_width_p-1:0] cnt_r;
    logic [dirs_lp-1:0]  dir_r;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p-1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // A full FIFO refuses a flit even when it dequeues in the same cycle.
    assign full    = (count_r == cnt_w_lp'(fifo_els_p));
    assign ready_o = ~full & ~reset_i;
    assign enq     = v_i & ready_o;
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq)    wptr_r <= ptr_inc(wptr_r);
            if (yumi_i) rptr_r <= ptr_inc(rptr_r);
            if (enq & ~yumi_i)      count_r <= count_r + cnt_w_lp'(1);
            else if (~enq & yumi_i) count_r <= count_r - cnt_w_lp'(1);
        end
    end

    // FIFO storage; contents are only meaningful while occupied
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

    assign hdr = header_s'(data_o[hdr_w_lp-1:0]);

    // Dimension-ordered route of the head flit, interpreted as a header
    always_comb begin
        x_dir = dir_p;
        y_dir = dir_p;
        if (hdr.x < my_x_i)      x_dir = dir_w;
        else if (hdr.x > my_x_i) x_dir = dir_e;
        if (dims_p > 1) begin
            if (hdr.y < my_y_i)      y_dir = dir_n;
            else if (hdr.y > my_y_i) y_dir = dir_s;
        end
        if (XY_order_p != 0) route_idx = (x_dir != dir_p) ? x_dir : y_dir;
        else                 route_idx = (y_dir != dir_p) ? y_dir : x_dir;
        route_oh = '0;
        route_oh[route_idx] = 1'b1;
    end

    assign is_header_o = (state_r == eHeader);
    assign req_o       = v_o ? (is_header_o ? route_oh : dir_r) : '0;
    assign is_tail_o   = is_header_o ? (hdr.len == '0) : (cnt_r == len_width_p'(1));

    // Packet tracking: remember the direction and count body flits down to the tail
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eHeader;
            cnt_r   <= '0;
            dir_r   <= '0;
        end else if (yumi_i) begin
            if (state_r == eHeader) begin
                if (hdr.len != '0) begin
                    state_r <= eBody;
                    cnt_r   <= hdr.len;
                    dir_r   <= route_oh;
                end
            end else begin
                cnt_r <= cnt_r - len_width_p'(1);
                if (cnt_r == len_width_p'(1)) state_r <= eHeader;
            end
        end
    end

    // A correct DOR never sends a flit back out of the side port it arrived on
    always_ff @(posedge clk_i) begin
        if (!reset_i && debug_p != 0 && v_o && is_header_o && port_id_p != dir_p)
            assert (!route_oh[port_id_p]) else $fatal(1, "u-turn on port %0d", port_id_p);
    end

endmodule

// File: rtl/bsg_mesh_router_wormhole_buffered.sv
// rtl/bsg_mesh_router_wormhole_buffered.sv - input-buffered wormhole mesh router with per-output locks
module bsg_mesh_router_wormhole_buffered
    import bsg_mesh_router_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int x_cord_width_p = 3,
    parameter int y_cord_width_p = 3,
    parameter int len_width_p    = 4,
    parameter int dims_p         = 2,
    parameter int dirs_lp        = 2*dims_p+1,
    parameter int fifo_els_p     = 2,
    parameter int XY_order_p     = 1,
    parameter int debug_p        = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [dirs_lp-1:0][width_p-1:0] data_i,
    input  logic [dirs_lp-1:0]              v_i,
    output logic [dirs_lp-1:0]              ready_o,
    output logic [dirs_lp-1:0][width_p-1:0] data_o,
    output logic [dirs_lp-1:0]              v_o,
    input  logic [dirs_lp-1:0]              ready_i,
    input  logic [x_cord_width_p-1:0]       my_x_i,
    input  logic [y_cord_width_p-1:0]       my_y_i
);

    localparam int idx_w_lp = $clog2(dirs_lp);

    logic [dirs_lp-1:0] in_v, in_hdr, in_tail, in_yumi;
    logic [width_p-1:0] in_data [dirs_lp];
    logic [dirs_lp-1:0] in_req  [dirs_lp];   // [input] -> one-hot output
    logic [dirs_lp-1:0] out_sel [dirs_lp];   // [output] -> one-hot input

    for (genvar i = 0; i < dirs_lp; i++) begin : g_in
        bsg_mesh_router_wormhole_input #(
            .width_p(width_p), .x_cord_width_p(x_cord_width_p),
            .y_cord_width_p(y_cord_width_p), .len_width_p(len_width_p),
            .dims_p(dims_p), .dirs_lp(dirs_lp), .fifo_els_p(fifo_els_p),
            .XY_order_p(XY_order_p), .debug_p(debug_p), .port_id_p(i)
        ) u_input (
            .clk_i(clk_i), .reset_i(reset_i),
            .data_i(data_i[i]), .v_i(v_i[i]), .ready_o(ready_o[i]),
            .my_x_i(my_x_i), .my_y_i(my_y_i),
            .v_o(in_v[i]), .data_o(in_data[i]), .req_o(in_req[i]),
            .is_header_o(in_hdr[i]), .is_tail_o(in_tail[i]),
            .yumi_i(in_yumi[i])
        );
    end

    for (genvar o = 0; o < dirs_lp; o++) begin : g_out
        wh_out_state_e       state_r;
        logic [idx_w_lp-1:0] owner_r, ptr_r, gnt_idx;
        logic [dirs_lp-1:0]  cand, gnt, sel;
        logic                gnt_v, xfer, sel_tail;
        logic [width_p-1:0]  mux;

        // Candidates are inputs whose head is a header routed to this output
        always_comb begin
            cand = '0;
            for (int i = 0; i < dirs_lp; i++)
                cand[i] = in_v[i] & in_hdr[i] & in_req[i][o];
        end

        // Round-robin grant, searching upward from the priority pointer
        always_comb begin
            gnt_v   = 1'b0;
            gnt_idx = '0;
            for (int k = 0; k < dirs_lp; k++) begin
                if (!gnt_v && cand[(int'(ptr_r) + k) % dirs_lp]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = idx_w_lp'((int'(ptr_r) + k) % dirs_lp);
                end
            end
            gnt = '0;
            if (gnt_v) gnt[gnt_idx] = 1'b1;
        end

        // While locked only the owner's head may pass
        always_comb begin
            sel = '0;
            if (state_r == eIdle) sel = gnt;
            else sel[owner_r] = in_v[owner_r] & in_req[owner_r][o];
        end

        // One-hot data mux; zero when nothing is selected
        always_comb begin
            mux = '0;
            for (int i = 0; i < dirs_lp; i++)
                mux = mux | (in_data[i] & {width_p{sel[i]}});
        end

        assign data_o[o]  = mux;
        assign v_o[o]     = |sel;
        assign out_sel[o] = sel;
        assign xfer       = v_o[o] & ready_i[o];
        assign sel_tail   = |(sel & in_tail);

        // Output lock: held from a multi-flit header until its tail transfers
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                state_r <= eIdle;
                owner_r <= '0;
                ptr_r   <= '0;
            end else if (xfer) begin
                if (state_r == eIdle) begin
                    ptr_r <= (gnt_idx == idx_w_lp'(dirs_lp-1)) ? '0 : gnt_idx + idx_w_lp'(1);
                    if (!sel_tail) begin
                        state_r <= eLocked;
                        owner_r <= gnt_idx;
                    end
                end else if (sel_tail) begin
                    state_r <= eIdle;
                end
            end
        end
    end

    // Dequeue an input head when the output it was selected for accepts it
    always_comb begin
        in_yumi = '0;
        for (int o = 0; o < dirs_lp; o++)
            for (int i = 0; i < dirs_lp; i++)
                in_yumi[i] = in_yumi[i] | (out_sel[o][i] & ready_i[o]);
    end

endmodule

// File: tb/tb_bsg_mesh_router_wormhole_buffered.sv
// tb/tb_bsg_mesh_router_wormhole_buffered.sv - scoreboard bench for the wormhole mesh router
module tb_bsg_mesh_router_wormhole_buffered;

    localparam int W = 16;
    localparam int D = 5;
    localparam int PP = 0, PW = 1, PE = 2, PN = 3, PS = 4;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_i = 1'b1;
    logic [D-1:0][W-1:0] data_i, data_o;
    logic [D-1:0]        v_i, ready_o, v_o, ready_i;
    logic [2:0]          my_x = 3'd2;
    logic [2:0]          my_y = 3'd2;

    bsg_mesh_router_wormhole_buffered #(
        .width_p(W), .x_cord_width_p(3), .y_cord_width_p(3), .len_width_p(4),
        .dims_p(2), .fifo_els_p(2), .XY_order_p(1), .debug_p(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
        .my_x_i(my_x), .my_y_i(my_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] flitq [D][$];
    exp_t         expq  [D*D][$];
    int           mrem [D], mroute [D], acc_cnt [D];
    int           orem [D], osrc [D], out_cnt [D];
    int           plog [$];
    bit           rand_mode = 0, strict_lat = 0;
    logic [D-1:0] block = '0;
    int           vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Dimension-ordered routing from this node at (2,2), X first
    function automatic int dor(input int x, input int y);
        if (x < 2) return PW;
        if (x > 2) return PE;
        if (y < 2) return PN;
        if (y > 2) return PS;
        return PP;
    endfunction

    task automatic make_pkt(input int p, input int x, input int y, input int len);
        logic [W-1:0] f;
        f = {p[2:0], 3'($urandom), len[3:0], y[2:0], x[2:0]};
        flitq[p].push_back(f);
        for (int b = 0; b < len; b++) begin
            f = {p[2:0], 13'($urandom)};
            flitq[p].push_back(f);
        end
    endtask

    // Reference model: header picks the output, body flits follow it
    task automatic accept(input int p, input logic [W-1:0] f);
        int r;
        exp_t e;
        if (mrem[p] == 0) begin
            r = dor(int'(f[2:0]), int'(f[5:3]));
            mroute[p] = r;
            mrem[p] = int'(f[9:6]);
        end else begin
            r = mroute[p];
            mrem[p]--;
        end
        e.data = f;
        e.acc  = cyc;
        expq[r*D+p].push_back(e);
        acc_cnt[p]++;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        reset_i = 1'b1;
        for (int p = 0; p < D; p++) begin
            flitq[p].delete();
            mrem[p] = 0; acc_cnt[p] = 0; orem[p] = 0; out_cnt[p] = 0;
        end
        for (int q = 0; q < D*D; q++) expq[q].delete();
        plog.delete();
        repeat (n) @(posedge clk);
        #2 reset_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy = 0;
            for (int p = 0; p < D; p++) if (flitq[p].size() != 0) busy = 1;
            for (int q = 0; q < D*D; q++) if (expq[q].size() != 0) busy = 1;
        end while (busy && n < budget);
        check(name, busy, 0);
    endtask

    // Driver: present queued flits, drive downstream ready, record accepts
    initial begin : driver
        v_i = '0; data_i = '0; ready_i = '1;
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < D; p++) begin
                if (flitq[p].size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    v_i[p] = 1'b1;
                    data_i[p] = flitq[p][0];
                end else begin
                    v_i[p] = 1'b0;
                    data_i[p] = '0;
                end
                ready_i[p] = ~block[p] & (!rand_mode || $urandom_range(0, 4) != 0);
            end
            @(negedge clk);
            for (int p = 0; p < D; p++)
                if (v_i[p] && ready_o[p] && !reset_i) accept(p, flitq[p].pop_front());
        end
    end

    // Monitor: every output transfer is matched against the model's queues
    initial begin : monitor
        logic [W-1:0] f;
        int s;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                for (int o = 0; o < D; o++) begin
                    if (v_o[o] && ready_i[o]) begin
                        f = data_o[o];
                        out_cnt[o]++;
                        if (orem[o] == 0) begin
                            s = int'(f[15:13]);
                            osrc[o] = s;
                        end else s = osrc[o];
                        if (o == PP) plog.push_back(int'(f[15:13]));
                        if (s >= D || expq[o*D+s].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_flit out%0d: got %0h expected none", o, f);
                            orem[o] = 0;
                        end else begin
                            e = expq[o*D+s].pop_front();
                            check($sformatf("data_out%0d", o), f, e.data);
                            check($sformatf("latency_min_out%0d", o), cyc > e.acc, 1);
                            if (strict_lat) check($sformatf("latency_out%0d", o), cyc, e.acc + 1);
                            orem[o] = (orem[o] == 0) ? int'(e.data[9:6]) : orem[o] - 1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int seq, n, snap, x, y, len;
        for (int p = 0; p < D; p++) begin
            mrem[p] = 0; acc_cnt[p] = 0; orem[p] = 0; osrc[p] = 0; out_cnt[p] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_v_o", v_o, 0);
        check("reset_data_o", |data_o, 0);
        check("reset_ready_o", ready_o, 0);
        @(posedge clk); #2 reset_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ready_o, 64'h1f);

        // Single-flit eject
        strict_lat = 1;
        make_pkt(PP, 2, 2, 0);
        @(negedge clk); @(negedge clk);
        check("eject_ready_p", ready_o[PP], 1);
        wait_drain("eject_drain", 50);
        check("eject_count", out_cnt[PP], 1);

        // XY turn: W to S, four flits back to back
        do_reset(2);
        make_pkt(PW, 2, 4, 3);
        wait_drain("xy_drain", 50);
        check("xy_count", out_cnt[PS], 4);

        // Lock hold: W and E race for P
        do_reset(2);
        strict_lat = 0;
        make_pkt(PW, 2, 2, 2);
        make_pkt(PE, 2, 2, 2);
        wait_drain("lock_drain", 100);
        seq = 0;
        foreach (plog[i]) seq = seq * 8 + plog[i];
        check("lock_order", seq, 'o111222);

        // Back-pressure mid-packet on E
        do_reset(2);
        make_pkt(PW, 5, 2, 4);
        n = 0;
        while (out_cnt[PE] < 1 && n < 50) begin @(negedge clk); n++; end
        check("bp_first_out", out_cnt[PE] >= 1, 1);
        block[PE] = 1'b1;
        repeat (2) @(negedge clk);
        snap = out_cnt[PE];
        repeat (5) @(negedge clk);
        check("bp_ready_drop", ready_o[PW], 0);
        check("bp_hold", out_cnt[PE], snap);
        block[PE] = 1'b0;
        wait_drain("bp_drain", 100);
        check("bp_count", out_cnt[PE], 5);

        // Reset mid-packet, then a fresh packet
        do_reset(2);
        make_pkt(PW, 2, 4, 3);
        n = 0;
        while (acc_cnt[PW] < 2 && n < 50) begin @(negedge clk); n++; end
        check("rst_partial_accept", acc_cnt[PW] >= 2, 1);
        do_reset(1);
        @(negedge clk);
        check("rst_v_o", v_o, 0);
        check("rst_data_o", |data_o, 0);
        strict_lat = 1;
        make_pkt(PW, 2, 4, 3);
        wait_drain("rst_drain", 100);
        check("rst_new_count", out_cnt[PS], 4);

        // Randomized traffic from all ports with random back-pressure
        do_reset(2);
        strict_lat = 0;
        rand_mode = 1;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < D; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    do begin
                        x = int'($urandom_range(0, 7));
                        y = int'($urandom_range(0, 7));
                    end while (p != PP && dor(x, y) == p);
                    len = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
                    make_pkt(p, x, y, len);
                end
            end
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        wait_drain("random_drain", 20000);
        rand_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
